// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types for the round-robin 4:1 mux arbiter.
package rr_mux4_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux4.sv
// Plain W-bit 4:1 multiplexer shared by the arbiter data path.
module mux4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  // Select one of four words.
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester set, searching
// last+1, last+2, last+3, last (all modulo 4).
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       last,
  output sel_t       gnt,
  output logic       any
);

  logic [7:0] req2;
  logic [2:0] start;
  logic [3:0] rot;
  sel_t       off;

  // Rotate the request vector so bit 0 is the highest-priority slot, then
  // priority-encode and rotate the index back.
  always_comb begin
    req2  = {req, req};
    start = {1'b0, last} + 3'd1;
    rot   = req2[start +: 4];
    off   = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    gnt = last + 2'd1 + off;
    any = |req;
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four valid/ready requesters,
// feeding a one-entry registered output channel.
// Optional feature macro RR_ARB_BURST_EN: allows up to MAX_BURST consecutive
// grants to the same requester before rotating.
//
// Handshake: a word moves on a rising edge when valid and ready are both high
// on that channel; valid never depends on ready of the same channel, while
// in_ready depends combinationally on in_valid and out_ready.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int W         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_src,
  output logic         dbg_state
);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("MAX_BURST must be at least 1");
  end

  arb_state_t   state_q, state_d;
  logic [W-1:0] data_q, data_d;
  sel_t         src_q, src_d;
  sel_t         last_q, last_d;

  sel_t         pick_gnt;
  logic         any;
  sel_t         g;
  logic [W-1:0] mux_y;
  logic         can_load;
  logic         accept;

  rr_pick4 u_pick (
    .req  (in_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .any  (any)
  );

`ifdef RR_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold;

  // Keep granting the previous winner while it still requests and has burst
  // budget left; a non-zero count means the last accept went to last_q.
  always_comb begin
    hold  = (cnt_q != '0) && in_valid[last_q] && (int'(cnt_q) < MAX_BURST);
    g     = hold ? last_q : pick_gnt;
    cnt_d = cnt_q;
    if (accept)        cnt_d = hold ? cnt_q + CNT_W'(1) : CNT_W'(1);
    else if (can_load) cnt_d = '0;
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign g = pick_gnt;
`endif

  mux4 #(.W(W)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (g),
    .y   (mux_y)
  );

  // Accept only out of reset so in_ready stays low while rst_n is asserted.
  assign can_load = (state_q == EMPTY) | out_ready;
  assign accept   = can_load & any & rst_n;

  // One-hot ready to the granted requester on an accept.
  always_comb begin
    in_ready = 4'b0000;
    if (accept) in_ready[g] = 1'b1;
  end

  // Output-slot FSM: next state and register loads.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (out_ready && !accept) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      data_d = mux_y;
      src_d  = g;
      last_d = g;
    end
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Testbench for rr_mux4_arbiter: directed vectors, a behavioural model of the
// arbitration rules, an expected-word queue, and literal pin-point checks.
module tb_rr_mux4_arbiter;

  localparam int W    = 4;
  localparam int MAXB = 2;
`ifdef RR_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         dbg_state;

  rr_mux4_arbiter #(.W(W), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_data;
  logic         m_valid;
  logic [1:0]   m_src;
  logic [1:0]   m_last;
  int           m_cnt;
  logic         m_hold;
  logic [1:0]   m_g;
  logic         m_accept;
  logic [W+1:0] exp_q[$];

  function automatic logic [1:0] rotate_pick(input logic [3:0] v, input logic [1:0] last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(last) + k) % 4;
      if (v[idx]) return idx[1:0];
    end
    return 2'd0;
  endfunction

  function automatic logic [W-1:0] word_of(input logic [1:0] s);
    logic [W-1:0] words[4];
    words[0] = d0; words[1] = d1; words[2] = d2; words[3] = d3;
    return words[s];
  endfunction

  always_comb begin
    m_hold   = BURST && (m_cnt > 0) && in_valid[m_last] && (m_cnt < MAXB);
    m_g      = m_hold ? m_last : rotate_pick(in_valid, m_last);
    m_accept = rst_n && (!m_valid || out_ready) && (in_valid != 4'b0000);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= 2'd0;
      m_last  <= 2'd3;
      m_cnt   <= 0;
      exp_q.delete();
    end else if (!m_valid || out_ready) begin
      if (in_valid != 4'b0000) begin
        m_valid <= 1'b1;
        m_data  <= word_of(m_g);
        m_src   <= m_g;
        m_last  <= m_g;
        m_cnt   <= m_hold ? m_cnt + 1 : 1;
        exp_q.push_back({m_g, word_of(m_g)});
      end else begin
        m_valid <= 1'b0;
        m_cnt   <= 0;
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    logic [W+1:0] w;
    check("in_ready",  in_ready,  m_accept ? (4'b0001 << m_g) : 4'b0000);
    check("out_valid", out_valid, m_valid);
    check("out_data",  out_data,  m_data);
    check("out_src",   out_src,   m_src);
    check("dbg_state", dbg_state, m_valid);
    if (rst_n && m_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check("sb_data", out_data, w[W-1:0]);
        check("sb_src",  out_src,  w[W+1:W]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  int exp_rot_src[5]  = '{0, 1, 2, 3, 0};
  int exp_rot_data[5] = '{1, 2, 3, 4, 1};
`ifdef RR_ARB_BURST_EN
  int exp_pair_src[6] = '{1, 1, 2, 2, 1, 1};
`else
  int exp_pair_src[6] = '{1, 2, 1, 2, 1, 2};
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    out_ready = 1'b1;

    // Reset state, in_ready held low during reset even with requests.
    @(negedge clk);
    check("rst_in_ready",  in_ready,  4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  4'h0);
    check("rst_out_src",   out_src,   2'd0);

    // Single requester 2.
    next_cycle();
    rst_n = 1'b1; in_valid = 4'b0100; d2 = 4'hA;
    @(negedge clk);
    check("single_in_ready", in_ready, 4'b0100);
    next_cycle();
    in_valid = 4'b0000;
    @(negedge clk);
    check("single_out_valid", out_valid, 1'b1);
    check("single_out_data",  out_data,  4'hA);
    check("single_out_src",   out_src,   2'd2);

    // Full rotation with all four valid.
    do_reset();
    in_valid = 4'b1111; d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      check("rot_src",  out_src,  exp_rot_src[i]);
      check("rot_data", out_data, exp_rot_data[i]);
    end

    // Stall: this edge loads requester 1, then the consumer holds off.
    next_cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data",     out_data, 4'd2);
      check("stall_src",      out_src,  2'd1);
      check("stall_in_ready", in_ready, 4'b0000);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 4'b0100);
    next_cycle();
    @(negedge clk);
    check("release_src",  out_src,  2'd2);
    check("release_data", out_data, 4'd3);

    // Wrap: requester 3 wins, then only 3 valid with last=3 wins again.
    next_cycle();
    in_valid = 4'b1000;
    @(negedge clk);
    check("wrap_self", in_ready, 4'b1000);
    next_cycle();
    in_valid = 4'b1001;
    @(negedge clk);
    check("wrap_to_0", in_ready, 4'b0001);
    next_cycle();
    @(negedge clk);
    check("wrap_src", out_src, 2'd0);

    // Asynchronous reset while holding a word.
    next_cycle();
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_in_ready",  in_ready,  4'b0000);
    check("async_out_src",   out_src,   2'd0);
    next_cycle();
    rst_n = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 4'b0001);
    next_cycle();
    @(negedge clk);
    check("post_rst_src", out_src, 2'd0);

    // Two requesters always valid.
    do_reset();
    in_valid = 4'b0110; d1 = 4'd5; d2 = 4'd6;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk);
      check("pair_src", out_src, exp_pair_src[i]);
    end

    // Idle drain.
    next_cycle();
    in_valid = 4'b0000;
    next_cycle();
    @(negedge clk);
    check("idle_out_valid", out_valid, 1'b0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin arbiter that shares one 4:1, W-bit multiplexer among four valid/ready requesters and drives a single registered output channel. Each cycle it picks one requester fairly, steers that requester's data through the mux with a 2-bit select, and captures the word into a one-entry output register. It sits between four producer blocks and one consumer that owns the shared mux path.

## Interface
- `W`, 4: data width of every requester and of the output.
- `MAX_BURST`, 4: maximum consecutive grants to one requester. Used only when `RR_ARB_BURST_EN` is defined; must be at least 1.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  4  requester i has a word; bit i belongs to requester i.
- `d0`, `d1`, `d2`, `d3`  input  W each  requester data.
- `in_ready`  output  4  one-hot or zero; bit i high means requester i's word is accepted this cycle.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  consumer accepts the word.
- `out_data`  output  W  registered mux output.
- `out_src`  output  2  index of the requester that supplied `out_data`, i.e. the registered mux select.

## Operation
- The output register can take a new word ("can_load") when `!out_valid | out_ready`.
- The grant is computed combinationally from `in_valid`, the rotating pointer `last` (2 bits) and the burst state. Grant g is the first requester with `in_valid` set, searching `last+1, last+2, last+3, last` modulo 4.
- `in_ready[g] = can_load & |in_valid`. All other bits are 0. `in_ready` depends combinationally on `in_valid` and `out_ready`.
- On an accept (`can_load & |in_valid`):
  - `out_data` is loaded from mux(`d0..d3`, sel=g).
  - `out_src` is loaded with g.
  - `out_valid` is set to 1.
  - `last` is loaded with g.
- If `can_load` is true but no `in_valid` bit is set, `out_valid` is set to 0. `out_data` and `out_src` keep their values.
- While `out_valid & !out_ready`, `out_data` and `out_src` must not change. `in_ready` is all zeros during this time.
- State machine:
  - EMPTY (`out_valid`=0): goes to FULL on an accept.
  - FULL: stays in FULL on stall, or on drain with a simultaneous accept. Goes to EMPTY on drain with no request.
- Arithmetic: `last` and g wrap modulo 4 (3+1 gives 0). The burst counter saturates at `MAX_BURST` and never wraps.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - `last`=3, so requester 0 has first priority after reset.
  - Burst count = 0.
  - `in_ready`=0 while `rst_n` is low.
- Latency: a word accepted at edge k is visible on `out_data` with `out_valid`=1 after edge k.
- Throughput: one word per cycle when `out_ready` is held at 1.
- Drain and load in the same cycle is legal and gives a bubble-free transfer.
- Fairness: with all four requesters valid and `out_ready`=1, grants follow 0,1,2,3,0,… and no requester waits more than 3 accepts.
- Reset asserted mid-operation: any held word is discarded and all registers return to their reset values asynchronously. A requester whose `in_ready` was high in that cycle has not transferred.
- A requester dropping `in_valid` while not granted has no effect. Requesters are expected to hold `in_valid` and data stable until they see `in_ready`.

## Configuration
- Macro: `RR_ARB_BURST_EN`.
- Defined:
  - If the previous accept went to requester `last`, and `in_valid[last]` is still 1, and burst count < `MAX_BURST`, then g = `last` and the count increments.
  - Otherwise the normal rotation applies and the count resets to 1 on the new grant.
  - The count clears to 0 when an idle cycle loads no word.
- Not defined: strict rotation as described in Operation. The burst counter and `MAX_BURST` logic are absent.

## Structure
- Package `rr_mux4_arbiter_pkg`:
  - `localparam N_REQ = 4`.
  - `typedef logic [1:0] sel_t`.
  - `typedef enum logic {EMPTY, FULL} arb_state_t`.
- Sub-module `rr_pick4`: combinational round-robin picker.
  - Inputs: `req[3:0]`, `last` (sel_t).
  - Outputs: `gnt` (sel_t), `any`.
- Data steering uses the team's existing 4:1 mux module.

## Test plan
- Reset, then only `in_valid`=4'b0100 with `d2`=4'hA and `out_ready`=1 → `in_ready`=4'b0100 in cycle 0. Next cycle `out_valid`=1, `out_data`=4'hA, `out_src`=2.
- All four valid with `d0..d3`=1,2,3,4 and `out_ready`=1 (burst disabled) → `out_src` sequence 0,1,2,3,0 and `out_data` sequence 1,2,3,4,1 on consecutive cycles.
- Load a word, then hold `out_ready`=0 for 3 cycles → `out_data` and `out_src` remain stable, `in_ready`=0000. On release, the next word appears the following cycle.
- `last`=3 and only requester 3 valid → g=3 (wrap to self). Then requesters 0 and 3 valid → g=0.
- Assert `rst_n`=0 while `out_valid`=1 → `out_valid` goes to 0 immediately. After release, first priority is requester 0.
- `RR_ARB_BURST_EN` with `MAX_BURST`=2 and requesters 1 and 2 always valid → `out_src` sequence 1,1,2,2,1,1.
